// File: rtl/hwpe_stream_parity_source_if.sv
// rtl/hwpe_stream_parity_source_if.sv - HWPE-Stream handshake bundle (valid/ready/data/strb)
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = (DATA_WIDTH >= 8) ? DATA_WIDTH / 8 : 1
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport master  (output valid, output data, output strb, input ready);
  modport slave   (input valid, input data, input strb, output ready);
  modport monitor (input valid, input data, input strb, input ready);
endinterface

// File: rtl/hwpe_stream_parity_source.sv
// rtl/hwpe_stream_parity_source.sv - parity stream generator and entry-point protocol checker
// Optional stall-stability checker: HWPE_STREAM_PARITY_SOURCE_STABILITY_CHECK_EN
module hwpe_stream_parity_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  hwpe_stream_intf_stream.monitor normal_i,
  hwpe_stream_intf_stream.master  parity_o,
  output logic                   fault_detected_o,
  output logic                   fault_sticky_o,
  output logic [CNT_WIDTH-1:0]   fault_count_o
);

  localparam int unsigned ELEM_WIDTH = DATA_WIDTH / STRB_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if ((DATA_WIDTH % STRB_WIDTH) != 0) begin : gen_width_check
    $fatal(1, "DATA_WIDTH must be a multiple of STRB_WIDTH");
  end

  logic [STRB_WIDTH-1:0] parity_data;
  logic                  ready_fault;
  logic                  stab_fault;
  logic                  fault;
  logic                  sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  always_comb begin
    parity_data = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      parity_data[i] = ^normal_i.data[i*ELEM_WIDTH +: ELEM_WIDTH];
    end
  end

  assign parity_o.data  = parity_data;
  assign parity_o.strb  = normal_i.strb;
  assign parity_o.valid = normal_i.valid;

  // Both networks must see the same back-pressure whenever a beat is offered.
  assign ready_fault = normal_i.valid && (parity_o.ready != normal_i.ready);

`ifdef HWPE_STREAM_PARITY_SOURCE_STABILITY_CHECK_EN
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;

  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (clear_i) begin
      pending_d = 1'b0;
      data_d    = '0;
      strb_d    = '0;
    end else if (normal_i.valid && !normal_i.ready) begin
      // Snapshot only when the stall begins; later beats are compared against it.
      if (!pending_q) begin
        data_d = normal_i.data;
        strb_d = normal_i.strb;
      end
      pending_d = 1'b1;
    end else begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  assign stab_fault = pending_q &&
                      (!normal_i.valid || (normal_i.data != data_q) || (normal_i.strb != strb_q));
`else
  assign stab_fault = 1'b0;
`endif

  assign fault            = ready_fault | stab_fault;
  assign fault_detected_o = fault;

  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (clear_i) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (fault) begin
      sticky_d = 1'b1;
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign fault_sticky_o = sticky_q;
  assign fault_count_o  = count_q;

endmodule

// File: tb/tb_hwpe_stream_parity_source.sv
// tb/tb_hwpe_stream_parity_source.sv - directed bench for hwpe_stream_parity_source
module tb_hwpe_stream_parity_source;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 2;

`ifdef HWPE_STREAM_PARITY_SOURCE_STABILITY_CHECK_EN
  localparam logic STAB = 1'b1;
`else
  localparam logic STAB = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          fault_det;
  logic          fault_sticky;
  logic [CW-1:0] fault_count;

  int n_total;
  int n_bad;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) normal ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(SW), .STRB_WIDTH(SW)) parity ();

  hwpe_stream_parity_source #(
    .DATA_WIDTH(DW),
    .STRB_WIDTH(SW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .normal_i        (normal),
    .parity_o        (parity),
    .fault_detected_o(fault_det),
    .fault_sticky_o  (fault_sticky),
    .fault_count_o   (fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic pr,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    normal.valid = v;
    normal.ready = r;
    parity.ready = pr;
    normal.data  = d;
    normal.strb  = s;
    #1;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    clear   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    cyc();
    check("rst_sticky", {31'b0, fault_sticky}, 32'd0);
    check("rst_count", {30'b0, fault_count}, 32'd0);
    check("rst_fault", {31'b0, fault_det}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Parity: slices 0x01,0x03,0x07,0x00 from MSB -> bits 1,0,1,0
    drive(1'b1, 1'b1, 1'b1, 32'h0103_0700, 4'hF);
    check("par_data0", {28'b0, parity.data}, 32'h0000_000A);
    check("par_strb0", {28'b0, parity.strb}, 32'h0000_000F);
    check("par_valid0", {31'b0, parity.valid}, 32'd1);
    check("par_fault0", {31'b0, fault_det}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'h5);
    check("par_data1", {28'b0, parity.data}, 32'h0000_0001);
    check("par_strb1", {28'b0, parity.strb}, 32'h0000_0005);
    check("par_valid1", {31'b0, parity.valid}, 32'd0);
    cyc();

    // Ready mismatch for one cycle
    drive(1'b1, 1'b1, 1'b0, 32'h1234_5678, 4'hF);
    check("rdy_fault", {31'b0, fault_det}, 32'd1);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'hF);
    check("rdy_fault_gone", {31'b0, fault_det}, 32'd0);
    check("rdy_sticky", {31'b0, fault_sticky}, 32'd1);
    check("rdy_count", {30'b0, fault_count}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 4'hF);
    check("rdy_novalid", {31'b0, fault_det}, 32'd0);
    do_clear();
    check("clr_sticky", {31'b0, fault_sticky}, 32'd0);
    check("clr_count", {30'b0, fault_count}, 32'd0);

    // Stable stall for 3 cycles then handshake
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 4'hF);
      check("stall_stable", {31'b0, fault_det}, 32'd0);
      cyc();
    end
    drive(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 4'hF);
    check("stall_hs", {31'b0, fault_det}, 32'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("stall_count", {30'b0, fault_count}, 32'd0);

    // Data changes in cycle 2 of a stall
    drive(1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 4'hF);
    check("chg_c1", {31'b0, fault_det}, 32'd0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 32'hA5A5_A5A4, 4'hF);
    check("chg_c2", {31'b0, fault_det}, {31'b0, STAB});
    cyc();
    drive(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 4'hF);
    check("chg_c3", {31'b0, fault_det}, 32'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("chg_count", {30'b0, fault_count}, {31'b0, STAB});
    do_clear();

    // Valid drops while stalled
    drive(1'b1, 1'b0, 1'b0, 32'h0F0F_0F0F, 4'h3);
    check("drop_c1", {31'b0, fault_det}, 32'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F, 4'h3);
    check("drop_c2", {31'b0, fault_det}, {31'b0, STAB});
    cyc();
    check("drop_c3", {31'b0, fault_det}, 32'd0);
    check("drop_count", {30'b0, fault_count}, {31'b0, STAB});
    do_clear();

    // Saturation at 3 with CNT_WIDTH=2
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
      cyc();
    end
    check("sat_count", {30'b0, fault_count}, 32'd3);
    check("sat_sticky", {31'b0, fault_sticky}, 32'd1);
    clear = 1'b1;
    #1;
    check("clr_unmasked", {31'b0, fault_det}, 32'd1);
    cyc();
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("clr_prio_count", {30'b0, fault_count}, 32'd0);
    check("clr_prio_sticky", {31'b0, fault_sticky}, 32'd0);

    // Async reset during a stall with count=2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 4'hF);
      cyc();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h5555_0000, 4'hF);
    cyc();
    check("pre_rst_count", {30'b0, fault_count}, 32'd2);
    check("pre_rst_sticky", {31'b0, fault_sticky}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", {30'b0, fault_count}, 32'd0);
    check("arst_sticky", {31'b0, fault_sticky}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h5555_0001, 4'hF);
    check("rst_no_stab", {31'b0, fault_det}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h5555_0001, 4'hF);
    check("rst_rdy_fault", {31'b0, fault_det}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h5555_0001, 4'hF);
    rst_n = 1'b1;
    cyc();
    // Stall that was in progress at release is tracked from this edge on
    drive(1'b1, 1'b0, 1'b0, 32'h5555_0002, 4'hF);
    check("post_rst_chg", {31'b0, fault_det}, {31'b0, STAB});
    drive(1'b1, 1'b1, 1'b1, 32'h5555_0001, 4'hF);
    check("post_rst_hs", {31'b0, fault_det}, 32'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("post_rst_count", {30'b0, fault_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
